audio_pdm_decimator: RTL
========================

Name: audio_pdm_decimator

Overview:
- Receive-side counterpart of the team's first-order delta-sigma audio PWM/PDM modulator: recovers an unsigned WIDTH-bit sample from a 1-bit pulse-density stream.
- Boxcar (sinc1) counting decimator with a window of 2^DECIM_LOG2 clocks. Emits one registered sample plus a 1-cycle valid strobe per window.
- Used for loopback self-test of the audio path and for digitising an external 1-bit comparator/PDM source.

Parameters:
- WIDTH, 6, output sample width in bits.
- DECIM_LOG2, 6, log2 of window length in clocks; must be >= WIDTH (elaboration error otherwise).

Ports:
- clk  input  1  system clock
- rst  input  1  reset, asynchronous, active-high
- ena  input  1  decimator enable; low holds the block idle
- pdm  input  1  pulse-density input; asynchronous, synchronised internally
- data  output  WIDTH  last completed sample, unsigned
- valid  output  1  one-cycle strobe when data updates
- busy  output  1  high in SETTLE and RUN

Behaviour:
- Interface: one clock (clk); reset rst is asynchronous and active-high.
- Reset values: data=0, valid=0, busy=0, state=IDLE, synchroniser flops=0, phase=0, counters=0.
- Synchroniser: pdm passes through 2 flops that always run, independent of ena. Bit reaches the counter 2 clocks after the pin.
- phase: DECIM_LOG2-bit counter, +1 per clk while busy. It wraps naturally; terminal count is all-ones.
- Ones counter: DECIM_LOG2+1 bits, adds the synchronised bit each busy clk.
- At terminal phase, the window total is (counter + current bit). The counter clears to 0 on the same edge.
- Scaling: sample = total >> (DECIM_LOG2-WIDTH). If the scaled value is 2^WIDTH (all-ones input), clamp to 2^WIDTH-1.
- States:
  - IDLE: phase and counters held at 0; valid=0; data holds its last value. ena=1 -> SETTLE.
  - SETTLE: runs NSETTLE full windows (1 for sinc1) with results discarded. These windows contain stale synchroniser bits. After the last settle window -> RUN.
  - RUN: at each terminal phase, register data on the next edge and pulse valid for exactly 1 cycle.
- Timing: with ena rising before edge 0, the first valid is at cycle (NSETTLE+1)*2^DECIM_LOG2, i.e. cycle 128 for defaults. Cadence thereafter is exactly every 2^DECIM_LOG2 clocks.
- ena falls mid-window: on the next edge go to IDLE, discard the partial window, clear phase and counters, no valid. data is retained.
- ena falls on the terminal-phase cycle: that window is discarded and no valid is produced; ena has priority.
- rst mid-operation: everything returns to reset values immediately (asynchronous).
- Exactness: driven by a first-order modulator with constant input d, every aligned full window holds exactly d ones (DECIM_LOG2=WIDTH), so data=d.

Optional Feature:
- Macro AUDIO_PDM_SINC2_EN.
- Defined:
  - Second-order CIC (sinc2): two integrators run at clk rate and two combs at the decimated rate.
  - Register width 2*DECIM_LOG2+1; scaling shift is 2*DECIM_LOG2-WIDTH, with the same clamp.
  - NSETTLE=2; first valid at cycle 3*2^DECIM_LOG2 (192 for defaults).
  - Steady-state constant-input result equals the sinc1 result; step response settles over 2 windows.
- Undefined: sinc1 as above, NSETTLE=1, no integrator/comb logic synthesised.

Decomposition:
- Package audio_pkg:
  - state enum (IDLE, SETTLE, RUN)
  - localparam function settle_windows(sinc2) returning 1 or 2
  - shared clamp/scale function
- Sub-module audio_pdm_sync: 2-flop synchroniser with async reset. Reusable for other pin inputs.
- Filter arithmetic stays in the top module.

Test Plan:
- Loopback from a behavioural first-order modulator, data=32, defaults: first valid at cycle 128; then data=32 with valid every 64 clocks for 10 windows (192 and 32 under SINC2).
- pdm tied 1 -> data=63 (clamped); pdm tied 0 -> data=0; each after settle.
- Step modulator input 10 -> 50 mid-stream:
  - sinc1: one intermediate sample, then 50 constant.
  - sinc2: settles within 2 windows to 50.
- ena dropped at phase 30: no valid, busy=0 next cycle, data holds prior 32. Re-enable: first valid again 128 cycles later.
- rst asserted asynchronously mid-window at phase 40: data=0, valid=0, busy=0 immediately. After release and ena=1, normal timing resumes.
- DECIM_LOG2=8, WIDTH=6, data 20 scaled as 80/256 density -> data=20 (shift 2); valid period 256.

Source files
------------

// File: rtl/audio_pkg.sv
// Shared definitions for the PDM decimator: FSM encodings, settle-window
// count and the output scale/clamp helper.
//   No ports; imported with "import audio_pkg::*;".
package audio_pkg;

   localparam int unsigned STATE_W = 2;
   localparam int unsigned SCALE_W = 64;

   // Legacy-compatible state encoding (IDLE, SETTLE, RUN)
   typedef logic [STATE_W-1:0] state_t;
   localparam state_t ST_IDLE   = 2'd0;
   localparam state_t ST_SETTLE = 2'd1;
   localparam state_t ST_RUN    = 2'd2;

   // Windows discarded before the filter history holds only live input
   function automatic int unsigned settle_windows(input bit sinc2);
      return sinc2 ? 32'd2 : 32'd1;
   endfunction

   // Drop the fractional bits, then clamp the single overflow code
   // (full-scale input) to the largest representable sample.
   function automatic logic [SCALE_W-1:0] scale_clamp(input logic [SCALE_W-1:0] total,
                                                      input int unsigned       shift,
                                                      input int unsigned       width);
      logic [SCALE_W-1:0] scaled;
      logic [SCALE_W-1:0] limit;
      scaled = total >> shift;
      limit  = (SCALE_W'(1) << width) - SCALE_W'(1);
      return (scaled > limit) ? limit : scaled;
   endfunction

endpackage

// File: rtl/audio_pdm_sync.sv
// Two-flop synchroniser for an asynchronous single-bit pin.
//   clk      : system clock
//   rst      : asynchronous active-high reset (flops clear to 0)
//   async_in : raw pin
//   sync_out : synchronised copy, two clocks behind the pin
module audio_pdm_sync (
   input  logic clk,
   input  logic rst,
   input  logic async_in,
   output logic sync_out
);

   logic meta;

   // Free-running: never gated, so the chain is always primed
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         meta     <= 1'b0;
         sync_out <= 1'b0;
      end else begin
         meta     <= async_in;
         sync_out <= meta;
      end
   end

endmodule

// File: rtl/audio_pdm_decimator.sv
// Boxcar (sinc1) PDM decimator: counts ones over a 2^DECIM_LOG2-clock
// window and emits one WIDTH-bit unsigned sample with a 1-cycle valid.
// Define AUDIO_PDM_SINC2_EN to build a second-order CIC (sinc2) instead.
//   clk   : system clock
//   rst   : asynchronous active-high reset
//   ena   : enable; low returns the block to IDLE
//   pdm   : asynchronous pulse-density input
//   data  : last completed sample
//   valid : one-cycle strobe when data updates
//   busy  : high while settling or running
module audio_pdm_decimator
   import audio_pkg::*;
#(
   parameter int unsigned WIDTH      = 6,
   parameter int unsigned DECIM_LOG2 = 6
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             ena,
   input  logic             pdm,
   output logic [WIDTH-1:0] data,
   output logic             valid,
   output logic             busy
);

`ifdef AUDIO_PDM_SINC2_EN
   localparam bit          SINC2 = 1'b1;
`else
   localparam bit          SINC2 = 1'b0;
`endif
   localparam int unsigned NSETTLE = settle_windows(SINC2);
   localparam int unsigned ACC_W   = SINC2 ? (2 * DECIM_LOG2 + 1) : (DECIM_LOG2 + 1);
   localparam int unsigned SHIFT   = SINC2 ? (2 * DECIM_LOG2 - WIDTH) : (DECIM_LOG2 - WIDTH);
   localparam int unsigned SCNT_W  = 2;
   localparam logic [SCNT_W-1:0] SETTLE_LAST = SCNT_W'(NSETTLE - 1);

   if (DECIM_LOG2 < WIDTH) begin : g_bad_cfg
      $error("audio_pdm_decimator: DECIM_LOG2 must be >= WIDTH");
   end

   // Input synchroniser
   logic bit_s;

   audio_pdm_sync u_sync (
      .clk      (clk),
      .rst      (rst),
      .async_in (pdm),
      .sync_out (bit_s)
   );

   // Control state
   state_t                  state, state_nxt;
   logic [DECIM_LOG2-1:0]   phase, phase_nxt;
   logic [SCNT_W-1:0]       settle_cnt, settle_nxt;
   logic [WIDTH-1:0]        data_nxt;
   logic                    valid_nxt;
   logic                    busy_nxt;

   logic                    term_c;
   logic                    adv_c;
   logic [ACC_W-1:0]        total_c;
   logic [WIDTH-1:0]        sample_c;

   assign term_c   = (phase == '1);
   // Integrate only while busy and still enabled; ena low discards the window
   assign adv_c    = (state != ST_IDLE) && ena;
   assign sample_c = WIDTH'(scale_clamp(SCALE_W'(total_c), SHIFT, WIDTH));

`ifdef AUDIO_PDM_SINC2_EN
   // Two clk-rate integrators, two window-rate combs (modular arithmetic)
   logic [ACC_W-1:0] int1, int2, int2_d, comb1_d;
   logic [ACC_W-1:0] int1_nxt, int2_nxt, int2_d_nxt, comb1_d_nxt;
   logic [ACC_W-1:0] int1_sum_c, int2_sum_c, comb1_c;

   always_comb begin
      int1_nxt    = int1;
      int2_nxt    = int2;
      int2_d_nxt  = int2_d;
      comb1_d_nxt = comb1_d;
      int1_sum_c  = int1 + ACC_W'(bit_s);
      int2_sum_c  = int2 + int1_sum_c;
      comb1_c     = int2_sum_c - int2_d;
      total_c     = comb1_c - comb1_d;
      if (!adv_c) begin
         int1_nxt    = '0;
         int2_nxt    = '0;
         int2_d_nxt  = '0;
         comb1_d_nxt = '0;
      end else begin
         int1_nxt = int1_sum_c;
         int2_nxt = int2_sum_c;
         if (term_c) begin
            int2_d_nxt  = int2_sum_c;
            comb1_d_nxt = comb1_c;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         int1    <= '0;
         int2    <= '0;
         int2_d  <= '0;
         comb1_d <= '0;
      end else begin
         int1    <= int1_nxt;
         int2    <= int2_nxt;
         int2_d  <= int2_d_nxt;
         comb1_d <= comb1_d_nxt;
      end
   end
`else
   // Ones counter; the terminal-phase bit is folded into the total directly
   logic [ACC_W-1:0] acc, acc_nxt;

   always_comb begin
      acc_nxt = acc;
      total_c = acc + ACC_W'(bit_s);
      if (!adv_c || term_c) begin
         acc_nxt = '0;
      end else begin
         acc_nxt = total_c;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc <= '0;
      end else begin
         acc <= acc_nxt;
      end
   end
`endif

   // Next-state and registered-output logic
   always_comb begin
      state_nxt  = state;
      phase_nxt  = phase;
      settle_nxt = settle_cnt;
      data_nxt   = data;
      valid_nxt  = 1'b0;
      case (state)
         ST_IDLE: begin
            phase_nxt  = '0;
            settle_nxt = '0;
            if (ena) begin
               state_nxt = ST_SETTLE;
            end
         end
         ST_SETTLE, ST_RUN: begin
            if (!ena) begin
               state_nxt  = ST_IDLE;
               phase_nxt  = '0;
               settle_nxt = '0;
            end else begin
               phase_nxt = phase + DECIM_LOG2'(1);
               if (term_c) begin
                  if (state == ST_SETTLE) begin
                     if (settle_cnt == SETTLE_LAST) begin
                        state_nxt = ST_RUN;
                     end else begin
                        settle_nxt = settle_cnt + SCNT_W'(1);
                     end
                  end else begin
                     data_nxt  = sample_c;
                     valid_nxt = 1'b1;
                  end
               end
            end
         end
         default: begin
            state_nxt  = ST_IDLE;
            phase_nxt  = '0;
            settle_nxt = '0;
         end
      endcase
      busy_nxt = (state_nxt != ST_IDLE);
   end

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= ST_IDLE;
         phase      <= '0;
         settle_cnt <= '0;
         data       <= '0;
         valid      <= 1'b0;
         busy       <= 1'b0;
      end else begin
         state      <= state_nxt;
         phase      <= phase_nxt;
         settle_cnt <= settle_nxt;
         data       <= data_nxt;
         valid      <= valid_nxt;
         busy       <= busy_nxt;
      end
   end

endmodule
